// File: rtl/mem_pll_pkg.sv
// Shared types, default parameters and helpers for the memory PLL reset controller.
package mem_pll_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int unsigned DEF_MAX_RETRIES         = 3;
    localparam int unsigned DEF_SYNC_STAGES         = 2;

    // Width of the shared cycle counter: enough to hold the largest of the three cycle limits.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/mem_pll_sync.sv
// Multi-flop synchroniser for a single asynchronous bit, reset to 0.
module mem_pll_sync
    import mem_pll_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sr;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/mem_pll_rst_ctrl.sv
// Memory PLL supervisor: sequences the PLL reset, qualifies lock, and releases the
// memory-domain reset once lock has been stable. Runs entirely on refclk.
module mem_pll_rst_ctrl
    import mem_pll_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_reinit,
    output logic       pll_rst,
    output logic       domain_rst,
    output logic       ready,
    output logic       fault,
    output logic [7:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned CW = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);

    logic          lk;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          timeout;
    logic          lock_loss;
    logic [7:0]    retry_inc;

    mem_pll_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk(refclk),
        .rst(rst),
        .d  (pll_locked),
        .q  (lk)
    );

    // Next-state decode; sw_reinit overrides every other transition.
    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        lock_loss = 1'b0;
        retry_inc = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;
        if (sw_reinit) begin
            state_nxt = PLL_RST;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state_nxt = STABLE;
                    end else if (cnt == TO_LAST) begin
                        timeout   = 1'b1;
                        state_nxt = (MAX_RETRIES != 0 && 32'(retry_inc) == MAX_RETRIES)
                                    ? FAULT : PLL_RST;
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state_nxt = WAIT_LOCK;
                    end else if (cnt == STB_LAST) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        lock_loss = 1'b1;
                        state_nxt = PLL_RST;
                    end
                end
                FAULT:   state_nxt = FAULT;
                default: state_nxt = PLL_RST;
            endcase
        end
    end

    // State, shared counter, counters and outputs; outputs are registered from the next state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= PLL_RST;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            domain_rst    <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (sw_reinit || state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            pll_rst    <= (state_nxt == PLL_RST) || (state_nxt == FAULT);
            ready      <= (state_nxt == RUN);
            domain_rst <= (state_nxt != RUN);
            fault      <= (state_nxt == FAULT);
            if (sw_reinit) begin
                retry_cnt <= '0;
            end else if (timeout) begin
                retry_cnt <= retry_inc;
            end
            if (lock_loss && lock_loss_cnt != 8'hFF) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
        end
    end

endmodule
